mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing one main-memory bus between the instruction-fetch refill path (port I) and the data-cache refill/write-through path (port D) of the RISC-V core. It grants one requester at a time, drives the memory handshake, returns read data with a one-cycle ready pulse and times out hung transactions. It sits between the two cache controllers and the main-memory model in the top-level datapath.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, max cycles waiting for mem_ack before aborting (≥1, counter width $clog2(TIMEOUT+1))
- clk  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- i_req / d_req  in  1  request, held high until matching ready
- i_we / d_we  in  1  1 = write, 0 = read
- i_addr / d_addr  in  ADDR_W  word address, stable while req high
- i_wdata / d_wdata  in  DATA_W  write data, stable while req high
- i_rdata / d_rdata  out  DATA_W  registered read data, valid when ready=1
- i_ready / d_ready  out  1  one-cycle completion pulse
- i_err / d_err  out  1  pulses with ready when transaction timed out
- mem_req  out  1  memory request (registered)
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, sampled only in BUSY

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if any req, latch grant (gnt: 0=I, 1=D), copy granted we/addr/wdata into mem_* registers, set mem_req=1, clear timer → BUSY. No req → stay.
- Arbitration with no macro: D wins ties (fixed priority).
- BUSY: mem_req held; timer increments each cycle. mem_ack=1 → capture mem_rdata into granted port's rdata (reads only; writes leave rdata unchanged), mem_req=0 → DONE. Timer reaches TIMEOUT without ack → mem_req=0, set err flag, rdata unchanged → DONE. Ack and timeout in same cycle: ack wins, no err.
- DONE: granted port's ready=1 (err=1 if timed out) for exactly this cycle; other port's ready/err stay 0 → IDLE.
- mem_ack outside BUSY ignored.
- Requesters drop or change req at the edge ending DONE; arbiter re-evaluates in IDLE, so no double-grant.
- Reset values: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i/d_rdata=0, i/d_ready=0, i/d_err=0, gnt=0, timer=0, RR pointer=0.
- RST mid-transaction: next edge forces IDLE, mem_req=0; no ready pulse; pending ack discarded.

## Timing
- Req seen in IDLE cycle t → mem_req high from t+1.
- mem_ack in cycle k (k≥t+1) → ready pulse and valid rdata in cycle k+1.
- Minimum transaction: 3 cycles req-to-ready (t, t+1 ack, t+2 ready); next grant earliest at t+3.
- Timeout: ready+err in cycle t+TIMEOUT+2.
- No combinational path from req/mem_ack to any output.

## Configuration
- MEM_ARB_RR_EN defined: round-robin tie-break; 1-bit pointer records last-served port, updated at each grant; on tie, grant port not last served. Pointer resets to 0 (I last), so first tie goes to D.
- Undefined: fixed D-over-I priority, pointer not instantiated. Single-requester behaviour identical in both builds.

## Test plan
- Single I read: i_req, addr 0x10, memory acks 2 cycles later with 0xDEADBEEF → i_ready one cycle with i_rdata=0xDEADBEEF, d_ready stays 0.
- D write: d_we=1, addr 0x40, wdata 0x12345678 → mem_we=1, mem_addr=0x40, mem_wdata=0x12345678 next cycle; d_ready after ack; d_rdata unchanged.
- Tie, both req held for 4 transactions: fixed build → D,D,D,D while D held; MEM_ARB_RR_EN build → D,I,D,I.
- Timeout: TIMEOUT=15, never ack → d_ready and d_err high in cycle t+17, mem_req low; next request serviced normally.
- RST asserted in BUSY with ack next cycle → IDLE, mem_req=0, no ready/err pulse, all outputs at reset values.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester-port and memory-port bundles for mem_arbiter.
// master drives the request side; slave answers it.
interface mem_arbiter_req_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              err;

  modport master (output req, we, addr, wdata, input rdata, ready, err);
  modport slave  (input req, we, addr, wdata, output rdata, ready, err);
endinterface

interface mem_arbiter_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (I/D) arbiter onto one memory bus: req->ready min 3 cycles, ack->ready 1 cycle, timeout abort with err.
// Requests are held until ready; define MEM_ARB_RR_EN for round-robin tie-break, else D beats I.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              RST,
  mem_arbiter_req_if.slave  i_port,
  mem_arbiter_req_if.slave  d_port,
  mem_arbiter_mem_if.master mem
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic              gnt;
  logic [TW-1:0]     timer;
  logic              any_req;
  logic              pick;

  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              i_ready_q;
  logic              d_ready_q;
  logic              i_err_q;
  logic              d_err_q;

  assign any_req = i_port.req | d_port.req;

`ifdef MEM_ARB_RR_EN
  // last_gnt: 0 = I served last, 1 = D served last; a tie goes to the other one.
  logic last_gnt;

  assign pick = (i_port.req & d_port.req) ? ~last_gnt : d_port.req;

  always_ff @(posedge clk) begin
    if (RST) begin
      last_gnt <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_gnt <= pick;
    end
  end
`else
  assign pick = d_port.req;
`endif

  always_ff @(posedge clk) begin
    if (RST) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      timer       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_err_q     <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses raised only on entry to DONE.
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            gnt         <= pick;
            mem_we_q    <= pick ? d_port.we    : i_port.we;
            mem_addr_q  <= pick ? d_port.addr  : i_port.addr;
            mem_wdata_q <= pick ? d_port.wdata : i_port.wdata;
            mem_req_q   <= 1'b1;
            timer       <= '0;
            state       <= BUSY;
          end
        end

        BUSY: begin
          if (mem.ack) begin
            // Ack takes precedence over a timeout landing in the same cycle.
            mem_req_q <= 1'b0;
            state     <= DONE;
            if (gnt) begin
              d_ready_q <= 1'b1;
              if (!mem_we_q) d_rdata_q <= mem.rdata;
            end else begin
              i_ready_q <= 1'b1;
              if (!mem_we_q) i_rdata_q <= mem.rdata;
            end
          end else if (timer == TIMER_MAX) begin
            mem_req_q <= 1'b0;
            state     <= DONE;
            if (gnt) begin
              d_ready_q <= 1'b1;
              d_err_q   <= 1'b1;
            end else begin
              i_ready_q <= 1'b1;
              i_err_q   <= 1'b1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

  assign mem.req      = mem_req_q;
  assign mem.we       = mem_we_q;
  assign mem.addr     = mem_addr_q;
  assign mem.wdata    = mem_wdata_q;
  assign i_port.rdata = i_rdata_q;
  assign d_port.rdata = d_rdata_q;
  assign i_port.ready = i_ready_q;
  assign d_port.ready = d_ready_q;
  assign i_port.err   = i_err_q;
  assign d_port.err   = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single read/write, ack-outside-BUSY, timeout, reset mid-transaction, tie-break.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_req_if #(.ADDR_W(32), .DATA_W(32)) ip ();
  mem_arbiter_req_if #(.ADDR_W(32), .DATA_W(32)) dp ();
  mem_arbiter_mem_if #(.ADDR_W(32), .DATA_W(32)) mp ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk    (clk),
    .RST    (RST),
    .i_port (ip.slave),
    .d_port (dp.slave),
    .mem    (mp.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_i_ready"}, 32'(ip.ready), 32'd0);
    chk({tag, "_d_ready"}, 32'(dp.ready), 32'd0);
    chk({tag, "_i_err"},   32'(ip.err),   32'd0);
    chk({tag, "_d_err"},   32'(dp.err),   32'd0);
  endtask

  logic [31:0] exp_addr;
  logic        exp_d;

  initial begin
    ip.req = 0; ip.we = 0; ip.addr = '0; ip.wdata = '0;
    dp.req = 0; dp.we = 0; dp.addr = '0; dp.wdata = '0;
    mp.rdata = '0; mp.ack = 0;

    // Reset state
    tick(); tick();
    chk("rst_mem_req",   32'(mp.req), 32'd0);
    chk("rst_mem_we",    32'(mp.we),  32'd0);
    chk("rst_mem_addr",  mp.addr,     32'd0);
    chk("rst_mem_wdata", mp.wdata,    32'd0);
    chk("rst_i_rdata",   ip.rdata,    32'd0);
    chk("rst_d_rdata",   dp.rdata,    32'd0);
    chk_quiet("rst");
    RST = 0;
    tick();

    // Ack while idle must be ignored
    mp.ack = 1; mp.rdata = 32'h5555_5555;
    tick();
    mp.ack = 0;
    tick();
    chk_quiet("idle_ack");
    chk("idle_ack_i_rdata", ip.rdata, 32'd0);

    // Single I read, ack two cycles after the request
    ip.req = 1; ip.we = 0; ip.addr = 32'h10;
    tick();
    chk("ird_mem_req",  32'(mp.req), 32'd1);
    chk("ird_mem_addr", mp.addr,     32'h10);
    chk("ird_mem_we",   32'(mp.we),  32'd0);
    mp.ack = 1; mp.rdata = 32'hDEAD_BEEF;
    chk("ird_no_early_ready", 32'(ip.ready), 32'd0);
    tick();
    chk("ird_i_ready", 32'(ip.ready), 32'd1);
    chk("ird_i_rdata", ip.rdata,      32'hDEAD_BEEF);
    chk("ird_d_ready", 32'(dp.ready), 32'd0);
    chk("ird_i_err",   32'(ip.err),   32'd0);
    chk("ird_mem_req_low", 32'(mp.req), 32'd0);
    mp.ack = 0; ip.req = 0;
    tick();
    chk("ird_ready_pulse", 32'(ip.ready), 32'd0);
    chk("ird_rdata_hold",  ip.rdata,      32'hDEAD_BEEF);

    // D write
    dp.req = 1; dp.we = 1; dp.addr = 32'h40; dp.wdata = 32'h1234_5678;
    tick();
    chk("dwr_mem_we",    32'(mp.we), 32'd1);
    chk("dwr_mem_addr",  mp.addr,    32'h40);
    chk("dwr_mem_wdata", mp.wdata,   32'h1234_5678);
    mp.ack = 1; mp.rdata = 32'hAAAA_AAAA;
    tick();
    chk("dwr_d_ready", 32'(dp.ready), 32'd1);
    chk("dwr_d_rdata", dp.rdata,      32'd0);
    chk("dwr_i_ready", 32'(ip.ready), 32'd0);
    mp.ack = 0; dp.req = 0; dp.we = 0;
    tick();

    // D read timing out: request cycle t, ready+err at t+17
    dp.req = 1; dp.we = 0; dp.addr = 32'h80;
    tick();
    for (int c = 0; c < 15; c++) tick();
    chk("tmo_busy_mem_req", 32'(mp.req), 32'd1);
    chk("tmo_no_ready_yet", 32'(dp.ready), 32'd0);
    tick();
    chk("tmo_d_ready", 32'(dp.ready), 32'd1);
    chk("tmo_d_err",   32'(dp.err),   32'd1);
    chk("tmo_mem_req", 32'(mp.req),   32'd0);
    chk("tmo_d_rdata", dp.rdata,      32'd0);
    chk("tmo_i_ready", 32'(ip.ready), 32'd0);
    dp.req = 0;
    tick();
    chk("tmo_err_pulse", 32'(dp.err), 32'd0);

    // Normal D read after the timeout
    dp.req = 1; dp.addr = 32'h84;
    tick();
    chk("post_tmo_addr", mp.addr, 32'h84);
    mp.ack = 1; mp.rdata = 32'hCAFE_F00D;
    tick();
    chk("post_tmo_ready", 32'(dp.ready), 32'd1);
    chk("post_tmo_err",   32'(dp.err),   32'd0);
    chk("post_tmo_rdata", dp.rdata,      32'hCAFE_F00D);
    mp.ack = 0; dp.req = 0;
    tick();

    // Reset while BUSY, ack arriving the cycle after reset
    ip.req = 1; ip.we = 1; ip.addr = 32'h20; ip.wdata = 32'h0BAD_0BAD;
    tick();
    chk("rstb_mem_req_busy", 32'(mp.req), 32'd1);
    RST = 1; ip.req = 0; ip.we = 0;
    tick();
    RST = 0; mp.ack = 1; mp.rdata = 32'h7777_7777;
    chk("rstb_mem_req",   32'(mp.req), 32'd0);
    chk("rstb_mem_we",    32'(mp.we),  32'd0);
    chk("rstb_mem_addr",  mp.addr,     32'd0);
    chk("rstb_mem_wdata", mp.wdata,    32'd0);
    chk("rstb_i_rdata",   ip.rdata,    32'd0);
    chk("rstb_d_rdata",   dp.rdata,    32'd0);
    chk_quiet("rstb");
    tick();
    mp.ack = 0;
    chk_quiet("rstb_after_ack");
    chk("rstb_after_ack_mem_req", 32'(mp.req), 32'd0);
    tick();

    // Tie with both requests held for four transactions
    ip.req = 1; ip.we = 0; ip.addr = 32'h100;
    dp.req = 1; dp.we = 0; dp.addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      exp_addr = exp_d ? 32'h200 : 32'h100;
      tick();
      chk("tie_grant_addr", mp.addr, exp_addr);
      mp.ack = 1; mp.rdata = 32'h1000 + 32'(k);
      tick();
      mp.ack = 0;
      chk("tie_d_ready", 32'(dp.ready), 32'(exp_d));
      chk("tie_i_ready", 32'(ip.ready), 32'(!exp_d));
      if (k == 3) dp.req = 0;
      tick();
    end

    // D dropped: I finally served
    tick();
    chk("tail_grant_addr", mp.addr, 32'h100);
    mp.ack = 1; mp.rdata = 32'h0000_1234;
    tick();
    mp.ack = 0; ip.req = 0;
    chk("tail_i_ready", 32'(ip.ready), 32'd1);
    chk("tail_i_rdata", ip.rdata,      32'h0000_1234);
    chk("tail_d_ready", 32'(dp.ready), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
